// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia-set parameter controller:
// 5.13 fixed-point width, command op codes, FSM states and power-up defaults.
package julia_pkg;

  localparam int FIXED_W = 18;

  typedef logic signed [FIXED_W-1:0] fixed_t;

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_X_DEC    = 4'd1,
    OP_X_INC    = 4'd2,
    OP_Y_DEC    = 4'd3,
    OP_Y_INC    = 4'd4,
    OP_ZOOM_IN  = 4'd5,
    OP_ZOOM_OUT = 4'd6,
    OP_CR_INC   = 4'd7,
    OP_CR_DEC   = 4'd8,
    OP_CI_INC   = 4'd9,
    OP_CI_DEC   = 4'd10,
    OP_HOME     = 4'd11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_ISSUE,
    ST_WAIT_START,
    ST_WAIT_DONE
  } state_e;

  localparam fixed_t C_REAL_DEF = fixed_t'(-6554);
  localparam fixed_t C_COMP_DEF = fixed_t'(1278);
  localparam fixed_t X_DEF      = fixed_t'(0);
  localparam fixed_t Y_DEF      = fixed_t'(0);
  localparam fixed_t SCALE_DEF  = fixed_t'(16384);

  // Animation sweeps c_comp through [-1.0, 1.0) and wraps at the top.
  localparam fixed_t ANIM_WRAP_HI = fixed_t'(8192);
  localparam fixed_t ANIM_WRAP_LO = fixed_t'(-8192);

  // Codes 12-15 are reserved and treated exactly like NOP.
  function automatic logic op_is_nop(input op_e op);
    return (op == OP_NOP) || (op > OP_HOME);
  endfunction

endpackage

// File: rtl/julia_sat_add.sv
// Signed add with one guard bit, clamped to a configurable [MIN_VAL, MAX_VAL]
// window that must lie inside the W-bit signed range.
module julia_sat_add #(
  parameter int W       = 18,
  parameter int MIN_VAL = -(2 ** (W - 1)),
  parameter int MAX_VAL = (2 ** (W - 1)) - 1
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum
);

  localparam logic signed [W:0] MinExt = (W + 1)'(MIN_VAL);
  localparam logic signed [W:0] MaxExt = (W + 1)'(MAX_VAL);

  logic signed [W:0] wide;

  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    if (wide > MaxExt) begin
      sum = MaxExt[W-1:0];
    end else if (wide < MinExt) begin
      sum = MinExt[W-1:0];
    end else begin
      sum = wide[W-1:0];
    end
  end

endmodule

// File: rtl/julia_param_ctrl.sv
// Command-driven view/parameter controller feeding the julia_set_stripe array.
// Optional macro JULIA_ANIM_EN adds an anim_en input that self-issues c_comp steps.
module julia_param_ctrl
  import julia_pkg::*;
#(
  parameter int NUM_STRIPES = 2,
  parameter int PAN_SHIFT   = 3,
  parameter int C_STEP      = 82,
  parameter int SCALE_MIN   = 64,
  parameter int SCALE_MAX   = 65536
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      cmd_valid,
  input  logic [3:0]                cmd_op,
  output logic                      cmd_ready,
`ifdef JULIA_ANIM_EN
  input  logic                      anim_en,
`endif
  input  logic [NUM_STRIPES-1:0]    pause_in,
  output logic signed [FIXED_W-1:0] c_real,
  output logic signed [FIXED_W-1:0] c_comp,
  output logic signed [FIXED_W-1:0] x,
  output logic signed [FIXED_W-1:0] y,
  output logic signed [FIXED_W-1:0] scale,
  output logic                      valid,
  output logic                      update,
  output logic                      busy
);

  localparam fixed_t C_STEP_F = fixed_t'(C_STEP);

  state_e state_q, state_d;
  op_e    op_q;
  op_e    start_op;
  logic   start;
  logic   strobe_q;

  fixed_t pan_step, zoom_step;
  fixed_t x_b, y_b, scale_b, cr_b, ci_b;
  fixed_t x_sum, y_sum, scale_sum, cr_sum, ci_sum;

`ifdef JULIA_ANIM_EN
  logic anim_q;
`endif

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign valid     = strobe_q;
  assign update    = strobe_q;

  // An explicit command always wins over an animation step in the same cycle.
  always_comb begin
    start    = cmd_valid;
    start_op = op_e'(cmd_op);
`ifdef JULIA_ANIM_EN
    if (!cmd_valid && anim_en) begin
      start    = 1'b1;
      start_op = OP_CI_INC;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_WAIT_DONE;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= (state_d == ST_ISSUE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q <= OP_NOP;
`ifdef JULIA_ANIM_EN
      anim_q <= 1'b0;
`endif
    end else if (state_q == ST_IDLE && start) begin
      op_q <= start_op;
`ifdef JULIA_ANIM_EN
      anim_q <= !cmd_valid;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start) state_d = ST_APPLY;
      ST_APPLY:      state_d = op_is_nop(op_q) ? ST_IDLE : ST_ISSUE;
      ST_ISSUE:      state_d = ST_WAIT_START;
      ST_WAIT_START: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE:  if (&pause_in) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Step sizes track the current zoom so panning moves a fixed screen fraction.
  always_comb begin
    pan_step  = scale >>> PAN_SHIFT;
    zoom_step = scale >>> 2;
    x_b       = (op_q == OP_X_DEC)   ? -pan_step  : pan_step;
    y_b       = (op_q == OP_Y_DEC)   ? -pan_step  : pan_step;
    scale_b   = (op_q == OP_ZOOM_IN) ? -zoom_step : zoom_step;
    cr_b      = (op_q == OP_CR_DEC)  ? -C_STEP_F  : C_STEP_F;
    ci_b      = (op_q == OP_CI_DEC)  ? -C_STEP_F  : C_STEP_F;
  end

  julia_sat_add #(.W(FIXED_W)) u_sat_x (
    .a   (x),
    .b   (x_b),
    .sum (x_sum)
  );

  julia_sat_add #(.W(FIXED_W)) u_sat_y (
    .a   (y),
    .b   (y_b),
    .sum (y_sum)
  );

  julia_sat_add #(.W(FIXED_W), .MIN_VAL(SCALE_MIN), .MAX_VAL(SCALE_MAX)) u_sat_scale (
    .a   (scale),
    .b   (scale_b),
    .sum (scale_sum)
  );

  julia_sat_add #(.W(FIXED_W)) u_sat_cr (
    .a   (c_real),
    .b   (cr_b),
    .sum (cr_sum)
  );

  julia_sat_add #(.W(FIXED_W)) u_sat_ci (
    .a   (c_comp),
    .b   (ci_b),
    .sum (ci_sum)
  );

  // Parameters move only during APPLY so stripes never see a mid-frame change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      c_real <= C_REAL_DEF;
      c_comp <= C_COMP_DEF;
      x      <= X_DEF;
      y      <= Y_DEF;
      scale  <= SCALE_DEF;
    end else if (state_q == ST_APPLY) begin
      case (op_q)
        OP_X_DEC, OP_X_INC:      x      <= x_sum;
        OP_Y_DEC, OP_Y_INC:      y      <= y_sum;
        OP_ZOOM_IN, OP_ZOOM_OUT: scale  <= scale_sum;
        OP_CR_INC, OP_CR_DEC:    c_real <= cr_sum;
        OP_CI_INC: begin
`ifdef JULIA_ANIM_EN
          if (anim_q && (c_comp >= ANIM_WRAP_HI)) c_comp <= ANIM_WRAP_LO;
          else
`endif
          c_comp <= ci_sum;
        end
        OP_CI_DEC:               c_comp <= ci_sum;
        OP_HOME: begin
          c_real <= C_REAL_DEF;
          c_comp <= C_COMP_DEF;
          x      <= X_DEF;
          y      <= Y_DEF;
          scale  <= SCALE_DEF;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_param_ctrl.sv
// Directed self-checking bench for julia_param_ctrl (default build, animation off).
module tb_julia_param_ctrl;

  logic               clock = 1'b0;
  logic               reset;
  logic               cmd_valid;
  logic [3:0]         cmd_op;
  logic               cmd_ready;
  logic [1:0]         pause_in;
  logic signed [17:0] c_real, c_comp, x, y, scale;
  logic               valid, update, busy;

  int tests_run = 0;
  int tests_failed = 0;

  julia_param_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .pause_in  (pause_in),
    .c_real    (c_real),
    .c_comp    (c_comp),
    .x         (x),
    .y         (y),
    .scale     (scale),
    .valid     (valid),
    .update    (update),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic waitReady();
    int n = 0;
    while (!cmd_ready && n < 200) begin
      stepCycle();
      n++;
    end
    if (!cmd_ready) checkOutput("ready_timeout", 0, 1);
  endtask

  // Sends one command and returns once the controller is idle again.
  task automatic applyStimulus(input logic [3:0] op);
    waitReady();
    cmd_op    = op;
    cmd_valid = 1'b1;
    stepCycle();
    cmd_valid = 1'b0;
    waitReady();
  endtask

  task automatic checkDefaults(input string tag);
    checkOutput({tag, "_c_real"}, c_real, -6554);
    checkOutput({tag, "_c_comp"}, c_comp, 1278);
    checkOutput({tag, "_x"}, x, 0);
    checkOutput({tag, "_y"}, y, 0);
    checkOutput({tag, "_scale"}, scale, 16384);
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    pause_in  = 2'b00;
    stepCycle();
    stepCycle();
    checkDefaults("reset");
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_update", update, 0);
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_busy", busy, 1);

    // Power-up frame: stay busy until every stripe reports done.
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkOutput("powerup_busy", busy, 1);
      checkOutput("powerup_cmd_ready", cmd_ready, 0);
    end
    pause_in = 2'b11;
    stepCycle();
    checkOutput("powerup_ready", cmd_ready, 1);
    checkOutput("powerup_idle_busy", busy, 0);

    // Pan right with a cycle-accurate look at the strobe.
    cmd_op    = 4'd2;
    cmd_valid = 1'b1;
    stepCycle();
    cmd_valid = 1'b0;
    checkOutput("op2_apply_ready", cmd_ready, 0);
    checkOutput("op2_apply_valid", valid, 0);
    stepCycle();
    checkOutput("op2_x", x, 2048);
    checkOutput("op2_issue_valid", valid, 1);
    checkOutput("op2_issue_update", update, 1);
    stepCycle();
    checkOutput("op2_after_valid", valid, 0);
    checkOutput("op2_after_update", update, 0);
    waitReady();

    applyStimulus(4'd1);
    checkOutput("op1_x", x, 0);
    applyStimulus(4'd4);
    checkOutput("op4_y", y, 2048);
    applyStimulus(4'd3);
    checkOutput("op3_y", y, 0);
    applyStimulus(4'd7);
    checkOutput("op7_c_real", c_real, -6472);
    applyStimulus(4'd8);
    checkOutput("op8_c_real", c_real, -6554);
    applyStimulus(4'd9);
    checkOutput("op9_c_comp", c_comp, 1360);
    applyStimulus(4'd10);
    checkOutput("op10_c_comp", c_comp, 1278);

    // NOP and a reserved code: back to IDLE straight from APPLY, no strobe.
    cmd_op    = 4'd0;
    cmd_valid = 1'b1;
    stepCycle();
    cmd_valid = 1'b0;
    checkOutput("nop_apply_ready", cmd_ready, 0);
    stepCycle();
    checkOutput("nop_back_ready", cmd_ready, 1);
    checkOutput("nop_valid", valid, 0);
    cmd_op    = 4'd13;
    cmd_valid = 1'b1;
    stepCycle();
    cmd_valid = 1'b0;
    stepCycle();
    checkOutput("op13_back_ready", cmd_ready, 1);
    checkOutput("op13_valid", valid, 0);
    checkDefaults("nop");

    // Zoom in down to the floor, then out up to the ceiling.
    applyStimulus(4'd5);
    checkOutput("zoom_in_first", scale, 12288);
    for (int i = 1; i < 20; i++) applyStimulus(4'd5);
    checkOutput("zoom_in_floor", scale, 64);
    applyStimulus(4'd5);
    checkOutput("zoom_in_hold", scale, 64);
    applyStimulus(4'd2);
    checkOutput("pan_min_scale", x, 8);
    applyStimulus(4'd1);
    for (int i = 0; i < 45; i++) applyStimulus(4'd6);
    checkOutput("zoom_out_ceiling", scale, 65536);
    applyStimulus(4'd2);
    checkOutput("pan_max_scale", x, 8192);
    applyStimulus(4'd11);
    checkDefaults("home");

    // Walk c_real into the positive rail.
    for (int i = 0; i < 1678; i++) applyStimulus(4'd7);
    checkOutput("c_real_near_top", c_real, 131042);
    applyStimulus(4'd7);
    checkOutput("c_real_sat", c_real, 131071);
    applyStimulus(4'd7);
    checkOutput("c_real_no_wrap", c_real, 131071);
    applyStimulus(4'd8);
    checkOutput("c_real_leave_rail", c_real, 130989);
    applyStimulus(4'd11);

    // One stripe still busy: a held command must wait for the full frame.
    pause_in  = 2'b01;
    cmd_op    = 4'd4;
    cmd_valid = 1'b1;
    stepCycle();
    cmd_op = 4'd3;
    stepCycle();
    stepCycle();
    for (int i = 0; i < 8; i++) begin
      stepCycle();
      checkOutput("hold_busy", busy, 1);
      checkOutput("hold_cmd_ready", cmd_ready, 0);
      checkOutput("hold_y", y, 2048);
    end
    pause_in = 2'b11;
    stepCycle();
    checkOutput("release_ready", cmd_ready, 1);
    stepCycle();
    cmd_valid = 1'b0;
    checkOutput("release_accepted", busy, 1);
    stepCycle();
    checkOutput("release_y", y, 0);
    waitReady();

    // Reset during the ISSUE cycle drops the strobe without waiting for a clock.
    cmd_op    = 4'd2;
    cmd_valid = 1'b1;
    stepCycle();
    cmd_valid = 1'b0;
    stepCycle();
    checkOutput("pre_reset_valid", valid, 1);
    checkOutput("pre_reset_x", x, 2048);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_valid", valid, 0);
    checkOutput("async_update", update, 0);
    checkOutput("async_busy", busy, 1);
    checkOutput("async_cmd_ready", cmd_ready, 0);
    checkDefaults("async");
    stepCycle();
    reset = 1'b1;
    stepCycle();
    checkOutput("post_reset_ready", cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
